// File: rtl/lp_escape_tx_pkg.sv
// Shared C-PHY LP definitions: line states, escape FSM states, entry command codes.
// Reused by the receiver-side escape decoder.
package lp_escape_tx_pkg;

  // Line state is packed as {A, C}
  typedef logic [1:0] lp_line_t;

  localparam lp_line_t LP11 = 2'b11;
  localparam lp_line_t LP10 = 2'b10;
  localparam lp_line_t LP01 = 2'b01;
  localparam lp_line_t LP00 = 2'b00;

  typedef enum logic [2:0] {
    ST_STOP,
    ST_ENTRY,
    ST_CMD,
    ST_DATA,
    ST_PAUSE,
    ST_ULPS,
    ST_EXIT
  } esc_state_t;

  typedef enum logic [2:0] {
    CMD_LPDT,
    CMD_ULPS,
    CMD_TRIG0,
    CMD_TRIG1,
    CMD_TRIG2,
    CMD_TRIG3
  } esc_cmd_t;

  localparam logic [7:0] CODE_LPDT  = 8'b11100001;
  localparam logic [7:0] CODE_ULPS  = 8'b00011110;
  localparam logic [7:0] CODE_TRIG0 = 8'b01100010;
  localparam logic [7:0] CODE_TRIG1 = 8'b01011101;
  localparam logic [7:0] CODE_TRIG2 = 8'b00100001;
  localparam logic [7:0] CODE_TRIG3 = 8'b10100000;

  function automatic logic [7:0] cmd_code(input esc_cmd_t cmd);
    case (cmd)
      CMD_LPDT:  return CODE_LPDT;
      CMD_ULPS:  return CODE_ULPS;
      CMD_TRIG0: return CODE_TRIG0;
      CMD_TRIG1: return CODE_TRIG1;
      CMD_TRIG2: return CODE_TRIG2;
      default:   return CODE_TRIG3;
    endcase
  endfunction

  function automatic lp_line_t entry_line(input logic [1:0] phase);
    case (phase)
      2'd0:    return LP10;
      2'd1:    return LP00;
      2'd2:    return LP01;
      default: return LP00;
    endcase
  endfunction

endpackage

// File: rtl/lp_esc_bit_ser.sv
// 8-bit spaced-one-hot serializer: two half-bits per bit (mark, then LP-00 space).
// o_line_nxt is the line value for the following cycle so the parent can register it.
module lp_esc_bit_ser
  import lp_escape_tx_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_lsb_first,
  output lp_line_t   o_line_nxt,
  output logic       o_done
);

  logic [7:0] r_shift;
  logic [3:0] r_half;
  logic       r_busy;
  logic       r_lsb;
  logic       w_first_bit;
  logic       w_next_bit;

  assign w_first_bit = i_lsb_first ? i_data[0] : i_data[7];
  assign w_next_bit  = r_lsb ? r_shift[1] : r_shift[6];
  assign o_done      = r_busy && (r_half == 4'd15);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
      r_half  <= '0;
      r_busy  <= 1'b0;
      r_lsb   <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_half  <= '0;
      r_busy  <= 1'b1;
      r_lsb   <= i_lsb_first;
    end else if (r_busy) begin
      r_half <= r_half + 4'd1;
      // advance to the next bit when leaving a space half
      if (r_half[0])
        r_shift <= r_lsb ? {1'b0, r_shift[7:1]} : {r_shift[6:0], 1'b0};
      if (r_half == 4'd15)
        r_busy <= 1'b0;
    end
  end

  always_comb begin
    o_line_nxt = LP00;
    if (i_load)
      o_line_nxt = {w_first_bit, ~w_first_bit};
    else if (r_busy && r_half[0] && (r_half != 4'd15))
      o_line_nxt = {w_next_bit, ~w_next_bit};
  end

endmodule

// File: rtl/lp_escape_tx.sv
// LP escape-mode transmitter: entry, command code, LPDT payload / ULPS / trigger, exit.
// All line outputs and handshakes come straight from flops driven by next-state decode.
module lp_escape_tx
  import lp_escape_tx_pkg::*;
#(
  parameter int TLPX = 2
) (
  input  logic       TxClkEsc,
  input  logic       Rst,
  input  logic       TxRequestEsc,
  input  logic       TxLpdtEsc,
  input  logic       TxUlpsEsc,
  input  logic [3:0] TxTriggerEsc,
  input  logic [7:0] TxDataEsc,
  input  logic       TxValidEsc,
  output logic       TxReadyEsc,
  output logic       LpA,
  output logic       LpC,
  output logic       Stopstate
);

  localparam logic [3:0] TLPX_M1 = 4'(TLPX - 1);

  esc_state_t r_state, w_state_nxt;
  esc_cmd_t   r_cmd, w_cmd_nxt, w_cmd_sel;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [1:0] r_phase, w_phase_nxt;
  lp_line_t   r_line, w_line_nxt;
  logic       r_stop;
  logic       r_ready, w_ready_nxt;
  logic       w_mode_any;
  logic       w_boundary;
  logic       w_ser_load;
  logic [7:0] w_ser_data;
  logic       w_ser_lsb;
  lp_line_t   w_ser_line;
  logic       w_ser_done;

  lp_esc_bit_ser u_ser (
    .i_clk       (TxClkEsc),
    .i_rst       (Rst),
    .i_load      (w_ser_load),
    .i_data      (w_ser_data),
    .i_lsb_first (w_ser_lsb),
    .o_line_nxt  (w_ser_line),
    .o_done      (w_ser_done)
  );

  assign w_mode_any = TxLpdtEsc | TxUlpsEsc | (|TxTriggerEsc);

  always_comb begin
    w_cmd_sel = CMD_TRIG3;
    if (TxLpdtEsc)            w_cmd_sel = CMD_LPDT;
    else if (TxUlpsEsc)       w_cmd_sel = CMD_ULPS;
    else if (TxTriggerEsc[0]) w_cmd_sel = CMD_TRIG0;
    else if (TxTriggerEsc[1]) w_cmd_sel = CMD_TRIG1;
    else if (TxTriggerEsc[2]) w_cmd_sel = CMD_TRIG2;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    w_ready_nxt = 1'b0;
    w_ser_load  = 1'b0;
    w_ser_data  = TxDataEsc;
    w_ser_lsb   = 1'b1;
    w_boundary  = 1'b0;
    case (r_state)
      ST_STOP: begin
        if (TxRequestEsc && w_mode_any) begin
          w_state_nxt = ST_ENTRY;
          w_cmd_nxt   = w_cmd_sel;
          w_cnt_nxt   = TLPX_M1;
          w_phase_nxt = 2'd0;
        end
      end
      ST_ENTRY: begin
        if (r_cnt == 4'd0) begin
          w_cnt_nxt = TLPX_M1;
          if (r_phase == 2'd3) begin
            w_state_nxt = ST_CMD;
            w_ser_load  = 1'b1;
            w_ser_data  = cmd_code(r_cmd);
            w_ser_lsb   = 1'b0;
          end else begin
            w_phase_nxt = r_phase + 2'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_CMD: begin
        if (w_ser_done) begin
          case (r_cmd)
            CMD_LPDT: w_boundary = 1'b1;
            CMD_ULPS: w_state_nxt = ST_ULPS;
            default: begin
              w_state_nxt = ST_EXIT;
              w_cnt_nxt   = TLPX_M1;
            end
          endcase
        end
      end
      ST_DATA:  w_boundary = w_ser_done;
      ST_PAUSE: w_boundary = 1'b1;
      ST_ULPS: begin
        if (!TxRequestEsc) begin
          w_state_nxt = ST_EXIT;
          w_cnt_nxt   = TLPX_M1;
        end
      end
      ST_EXIT: begin
        if (r_cnt == 4'd0) w_state_nxt = ST_STOP;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: w_state_nxt = ST_STOP;
    endcase
    // LPDT byte boundary: the request is only looked at here
    if (w_boundary) begin
      if (!TxRequestEsc) begin
        w_state_nxt = ST_EXIT;
        w_cnt_nxt   = TLPX_M1;
      end else if (TxValidEsc) begin
        w_state_nxt = ST_DATA;
        w_ser_load  = 1'b1;
        w_ser_data  = TxDataEsc;
        w_ser_lsb   = 1'b1;
        w_ready_nxt = 1'b1;
      end else begin
        w_state_nxt = ST_PAUSE;
      end
    end
  end

  always_comb begin
    w_line_nxt = LP11;
    case (w_state_nxt)
      ST_STOP:           w_line_nxt = LP11;
      ST_ENTRY:          w_line_nxt = entry_line(w_phase_nxt);
      ST_CMD, ST_DATA:   w_line_nxt = w_ser_line;
      ST_PAUSE, ST_ULPS: w_line_nxt = LP00;
      ST_EXIT:           w_line_nxt = LP10;
      default:           w_line_nxt = LP11;
    endcase
  end

  always_ff @(posedge TxClkEsc or posedge Rst) begin
    if (Rst) begin
      r_state <= ST_STOP;
      r_cmd   <= CMD_LPDT;
      r_cnt   <= '0;
      r_phase <= '0;
      r_line  <= LP11;
      r_stop  <= 1'b1;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
      r_line  <= w_line_nxt;
      r_stop  <= (w_state_nxt == ST_STOP);
      r_ready <= w_ready_nxt;
    end
  end

  assign LpA        = r_line[1];
  assign LpC        = r_line[0];
  assign Stopstate  = r_stop;
  assign TxReadyEsc = r_ready;

endmodule
